ft245_fifo_ctrl: RTL
====================

// Module: ft245_fifo_ctrl
// PURPOSE
//   Sequences the FT245-style parallel USB FIFO shared by SoC TX and RX traffic.
//   Arbitrates one write requester (tx stream) against the read path (rx stream).
//   Generates the uart_rd/uart_wr strobes with programmable pulse and recovery timing.
//   Sits between the SoC and the top-level pad logic, which drives the bus while uart_wr=1.
// PARAMETERS
//   RD_CYCLES   4  cycles uart_rd held high; uart_rdata sampled on the last one (1..255)
//   WR_CYCLES   4  cycles uart_wr held high; wdata stable throughout (1..255)
//   REC_CYCLES  4  idle cycles after any strobe before txe/rxf are trusted again (2..255)
// PORTS
//   clk         in   1  system clock
//   rst_n       in   1  asynchronous active-low reset
//   tx_data     in   8  byte to send
//   tx_valid    in   1  tx_data valid
//   tx_ready    out  1  byte accepted this cycle (valid&ready = transfer)
//   rx_data     out  8  received byte
//   rx_valid    out  1  rx_data valid; held until rx_ready
//   rx_ready    in   1  consumer accepts rx_data
//   uart_rdata  in   8  FIFO data bus (input view)
//   uart_wdata  out  8  FIFO data bus (output view, pads drive it while uart_wr=1)
//   uart_txe    in   1  synchronized TXE#, 1 = FIFO cannot accept a write
//   uart_rxf    in   1  synchronized RXF#, 1 = FIFO has no data
//   uart_wr     out  1  write strobe, active high (inverted at pads)
//   uart_rd     out  1  read strobe, active high (inverted at pads)
//   busy        out  1  state != IDLE
// BEHAVIOUR
//   - rst_n=0 (asynchronous, any state): state=IDLE, counter=0, uart_wr=0, uart_rd=0,
//     rx_valid=0, rx_data=0, uart_wdata=0, last_grant=TX, busy=0. Mid-strobe reset
//     drops the strobe at once; no byte is delivered or acknowledged.
//   - States: IDLE, READ, WRITE, RECOVER. Single 8-bit down-counter shared by all.
//   - Eligibility (IDLE only): rx_ok = !uart_rxf && !rx_valid; tx_ok = tx_valid && !uart_txe.
//   - Arbitration: only one ok -> it wins; both -> side opposite last_grant wins
//     (round-robin); first contested grant after reset goes to RX. last_grant updates on grant.
//   - tx_ready = (state==IDLE) && tx_ok && tx granted; combinational, one cycle only.
//     On that edge tx_data -> uart_wdata, state -> WRITE, counter = WR_CYCLES-1.
//   - RX grant: state -> READ, counter = RD_CYCLES-1.
//   - READ: uart_rd=1 every cycle. When counter==0: rx_data <= uart_rdata, rx_valid <= 1,
//     state -> RECOVER, counter = REC_CYCLES-1. Else counter decrements.
//   - WRITE: uart_wr=1 every cycle, uart_wdata constant. counter==0 -> RECOVER as above.
//   - RECOVER: both strobes 0; counter==0 -> IDLE. Covers 2-flop sync latency of txe/rxf.
//   - Strobes are registered outputs: high exactly RD_CYCLES/WR_CYCLES consecutive cycles,
//     starting the cycle after the grant edge. Back-to-back transfer period =
//     1 + RD/WR_CYCLES + REC_CYCLES cycles.
//   - rx_valid clears on rx_valid&&rx_ready edge; rx_data holds. rx_ready while
//     rx_valid=0 is ignored. No new read starts while rx_valid=1 (RX back-pressure).
//   - uart_wdata holds its last value outside WRITE (bus released by pads since uart_wr=0).
//   - uart_rd and uart_wr are never high in the same cycle.
//   - txe/rxf changes outside IDLE are ignored; the transaction always runs to completion.
// TESTING
//   1 Reset: rst_n=0 mid-WRITE -> uart_wr falls same cycle, all outputs 0, busy=0.
//   2 RX: uart_rxf=0, uart_rdata=8'hA5, rx_ready=0 -> uart_rd high 4 cycles, rx_data=A5,
//     rx_valid=1 held; no second uart_rd pulse until rx_ready pulses.
//   3 TX: tx_valid=1, tx_data=8'h3C, uart_txe=0 -> tx_ready one cycle, uart_wr high 4 cycles
//     with uart_wdata=3C, then 4 recovery cycles before next tx_ready.
//   4 Contention: rxf=0, txe=0, tx_valid=1 continuous, rx_ready=1 -> grants alternate
//     RX,TX,RX,TX; each transaction spaced 9 cycles (defaults).
//   5 Flow control: uart_txe=1 with tx_valid=1 -> tx_ready stays 0, uart_wr stays 0;
//     txe=0 -> accepted next IDLE cycle. Same for rxf=1 on RX side.
//   6 Params RD=1,WR=1,REC=2 -> single-cycle strobes, period 4; rd/wr never overlap (assert).

Source files
------------

// File: rtl/ft245_fifo_ctrl_if.sv
// Bundle of SoC stream handshakes and FT245 FIFO bus signals.
// master is the controller view, slave is the SoC/pad view.
interface ft245_fifo_ctrl_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] uart_rdata;
  logic [7:0] uart_wdata;
  logic       uart_txe;
  logic       uart_rxf;
  logic       uart_wr;
  logic       uart_rd;

  modport master (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  uart_rdata,
    output uart_wdata,
    input  uart_txe,
    input  uart_rxf,
    output uart_wr,
    output uart_rd
  );

  modport slave (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output uart_rdata,
    input  uart_wdata,
    output uart_txe,
    output uart_rxf,
    input  uart_wr,
    input  uart_rd
  );
endinterface

// File: rtl/ft245_fifo_ctrl.sv
// FT245 parallel FIFO sequencer: round-robin TX/RX arbitration,
// timed read/write strobes and post-strobe recovery.
module ft245_fifo_ctrl #(
  parameter int unsigned RD_CYCLES  = 4,
  parameter int unsigned WR_CYCLES  = 4,
  parameter int unsigned REC_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  ft245_fifo_ctrl_if.master   bus,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    WRITE   = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam logic [7:0] RD_LOAD  = 8'(RD_CYCLES - 1);
  localparam logic [7:0] WR_LOAD  = 8'(WR_CYCLES - 1);
  localparam logic [7:0] REC_LOAD = 8'(REC_CYCLES - 1);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       last_rx_q;
  logic       last_rx_d;
  logic       rx_ok;
  logic       tx_ok;
  logic       grant_rx;
  logic       grant_tx;
  logic       rd_done;
  logic       rd_q;
  logic       wr_q;
  logic       rx_valid_q;
  logic [7:0] rx_data_q;
  logic [7:0] wdata_q;

  assign rx_ok   = !bus.uart_rxf && !rx_valid_q;
  assign tx_ok   = bus.tx_valid && !bus.uart_txe;
  assign rd_done = (state_q == READ) && (cnt_q == 8'd0);

  // last_rx_q=0 means TX held the last grant, so a reset
  // leaves the first contested grant to RX.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_rx_d = last_rx_q;
    grant_rx  = 1'b0;
    grant_tx  = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant_rx = rx_ok && (!tx_ok || !last_rx_q);
        grant_tx = tx_ok && !grant_rx;
        if (grant_rx) begin
          state_d   = READ;
          cnt_d     = RD_LOAD;
          last_rx_d = 1'b1;
        end else if (grant_tx) begin
          state_d   = WRITE;
          cnt_d     = WR_LOAD;
          last_rx_d = 1'b0;
        end
      end
      READ, WRITE: begin
        if (cnt_q == 8'd0) begin
          state_d = RECOVER;
          cnt_d   = REC_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RECOVER: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      last_rx_q <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_rx_q <= last_rx_d;
      rd_q      <= (state_d == READ);
      wr_q      <= (state_d == WRITE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdata_q <= 8'd0;
    end else if (grant_tx) begin
      wdata_q <= bus.tx_data;
    end
  end

  // A completing read only happens while rx_valid is low,
  // so the set and clear never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'd0;
    end else if (rd_done) begin
      rx_valid_q <= 1'b1;
      rx_data_q  <= bus.uart_rdata;
    end else if (rx_valid_q && bus.rx_ready) begin
      rx_valid_q <= 1'b0;
    end
  end

  assign bus.tx_ready   = grant_tx;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.rx_data    = rx_data_q;
  assign bus.uart_wdata = wdata_q;
  assign bus.uart_rd    = rd_q;
  assign bus.uart_wr    = wr_q;
  assign busy           = (state_q != IDLE);

endmodule
